parity_gen_tx: RTL and testbench

- Serial parity generator/transmitter; the sending end for the team's parity checker.
- Accepts a parallel data word over a valid/ready handshake and computes its even or odd parity.
- Shifts the word out LSB-first, one bit per clock, followed by one parity bit.
- Sits between a word producer and a serial link whose far end runs the parity check.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_calc.sv | 12 +
 rtl/parity_gen_tx.sv | 119 +++++++++++
 tb/tb_parity_gen_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity transmitter and checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bit-counter width able to hold DATA_W-1.
    function automatic int unsigned cnt_w(input int unsigned dataW);
        return $clog2(dataW);
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a word; sense=1 selects odd parity.
module parity_calc #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              sense,
    output logic              par_c
);

    assign par_c = (^data) ^ sense;

endmodule

// File: rtl/parity_gen_tx.sv
// Serial parity transmitter: word in over valid/ready, LSB-first bits out, then parity bit.
// Optional PARITY_ERR_INJ_EN adds err_inj to invert the transmitted parity bit per frame.
module parity_gen_tx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ODD_PAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
`ifdef PARITY_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic              din_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              sout_last,
    output logic              par_out,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_w(DATA_W);
    localparam logic        SENSE = (ODD_PAR != 0) ? PAR_ODD : PAR_EVEN;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bitCnt;
    logic              accept;
    logic              parC;
    logic              txPar;

    assign accept = din_valid & din_ready;

    parity_calc #(
        .DATA_W (DATA_W)
    ) uCalc (
        .data  (din),
        .sense (SENSE),
        .par_c (parC)
    );

`ifdef PARITY_ERR_INJ_EN
    logic errInjQ;

    // Injection request travels with the word it was accepted alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            errInjQ <= 1'b0;
        end else if (accept) begin
            errInjQ <= err_inj;
        end
    end

    assign txPar = par_out ^ errInjQ;
`else
    assign txPar = par_out;
`endif

    // Frame sequencer; bit 0 is registered onto sout at accept, shreg holds the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitCnt     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            par_out    <= 1'b0;
            busy       <= 1'b0;
            din_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, PARITY: begin
                    if (accept) begin
                        state      <= SHIFT;
                        shreg      <= din >> 1;
                        bitCnt     <= CNT_W'(DATA_W - 1);
                        par_out    <= parC;
                        sout       <= din[0];
                        sout_valid <= 1'b1;
                        sout_last  <= 1'b0;
                        busy       <= 1'b1;
                        din_ready  <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        busy       <= 1'b0;
                        din_ready  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bitCnt == '0) begin
                        state     <= PARITY;
                        sout      <= txPar;
                        sout_last <= 1'b1;
                        din_ready <= 1'b1;
                    end else begin
                        sout   <= shreg[0];
                        shreg  <= shreg >> 1;
                        bitCnt <= bitCnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sout_last  <= 1'b0;
                    busy       <= 1'b0;
                    din_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_gen_tx.sv
// Bench for parity_gen_tx: even and odd instances share stimulus, checked against a frame model.
module tb_parity_gen_tx;

    localparam int unsigned W = 8;
`ifdef PARITY_ERR_INJ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [5:0] MASK_ALL  = 6'b111111;
    localparam logic [5:0] MASK_IDLE = 6'b111011;  // par_out is unconstrained between frames
    localparam logic [5:0] IDLE_VEC  = 6'b000001;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         errInj;

    logic readyE, soutE, validE, lastE, parE, busyE;
    logic readyO, soutO, validO, lastO, parO, busyO;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    parity_gen_tx #(.DATA_W(W), .ODD_PAR(0)) dutEven (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
`ifdef PARITY_ERR_INJ_EN
        .err_inj    (errInj),
`endif
        .din_ready  (readyE),
        .sout       (soutE),
        .sout_valid (validE),
        .sout_last  (lastE),
        .par_out    (parE),
        .busy       (busyE)
    );

    parity_gen_tx #(.DATA_W(W), .ODD_PAR(1)) dutOdd (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
`ifdef PARITY_ERR_INJ_EN
        .err_inj    (errInj),
`endif
        .din_ready  (readyO),
        .sout       (soutO),
        .sout_valid (validO),
        .sout_last  (lastO),
        .par_out    (parO),
        .busy       (busyO)
    );

    // Observed output vector: {sout, sout_valid, sout_last, par_out, busy, din_ready}.
    function automatic logic [5:0] obsE();
        return {soutE, validE, lastE, parE, busyE, readyE};
    endfunction

    function automatic logic [5:0] obsO();
        return {soutO, validO, lastO, parO, busyO, readyO};
    endfunction

    // Reference frame: phases 0..W-1 carry word bits LSB-first, phase W carries the parity bit.
    function automatic logic [5:0] expVec(input int ph, input logic [W-1:0] w,
                                          input int odd, input logic err);
        logic par;
        logic tx;
        par = 1'(($countones(w) + odd) % 2);
        tx  = par ^ (ERR_EN & err);
        if (ph < int'(W))
            return {w[ph], 1'b1, 1'b0, par, 1'b1, 1'b0};
        return {tx, 1'b1, 1'b1, par, 1'b1, 1'b1};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        errInj = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (obsE() !== IDLE_VEC) begin
            testsFailed++;
            $display("FAIL reset_even got=%b exp=%b", obsE(), IDLE_VEC);
        end
        testsRun++;
        if (obsO() !== IDLE_VEC) begin
            testsFailed++;
            $display("FAIL reset_odd got=%b exp=%b", obsO(), IDLE_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame(input logic [W-1:0] w, input logic err);
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        errInj = err;
        for (int ph = 0; ph <= int'(W); ph++) begin
            @(negedge clk);
            if (ph == 0) begin
                din_valid = 1'b0;
                din = W'($urandom);
                errInj = 1'b0;
            end
            testsRun++;
            if (obsE() !== expVec(ph, w, 0, err)) begin
                testsFailed++;
                $display("FAIL frame_even w=%h err=%b ph=%0d got=%b exp=%b",
                         w, err, ph, obsE(), expVec(ph, w, 0, err));
            end
            testsRun++;
            if (obsO() !== expVec(ph, w, 1, err)) begin
                testsFailed++;
                $display("FAIL frame_odd w=%h err=%b ph=%0d got=%b exp=%b",
                         w, err, ph, obsO(), expVec(ph, w, 1, err));
            end
        end
        @(negedge clk);
        testsRun++;
        if ((obsE() & MASK_IDLE) !== IDLE_VEC || (obsO() & MASK_IDLE) !== IDLE_VEC) begin
            testsFailed++;
            $display("FAIL frame_idle w=%h got_even=%b got_odd=%b exp=%b",
                     w, obsE(), obsO(), IDLE_VEC);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[$];
        words = '{8'h01, 8'hFF, W'($urandom)};
        @(negedge clk);
        din = words[0];
        din_valid = 1'b1;
        errInj = 1'b0;
        foreach (words[k]) begin
            for (int ph = 0; ph <= int'(W); ph++) begin
                @(negedge clk);
                if (ph == 0) begin
                    if (k + 1 < words.size()) din = words[k + 1];
                    else din_valid = 1'b0;
                end
                testsRun++;
                if (obsE() !== expVec(ph, words[k], 0, 1'b0)) begin
                    testsFailed++;
                    $display("FAIL b2b_even k=%0d ph=%0d got=%b exp=%b",
                             k, ph, obsE(), expVec(ph, words[k], 0, 1'b0));
                end
                testsRun++;
                if (obsO() !== expVec(ph, words[k], 1, 1'b0)) begin
                    testsFailed++;
                    $display("FAIL b2b_odd k=%0d ph=%0d got=%b exp=%b",
                             k, ph, obsO(), expVec(ph, words[k], 1, 1'b0));
                end
            end
        end
        @(negedge clk);
        testsRun++;
        if ((obsE() & MASK_IDLE) !== IDLE_VEC || (obsO() & MASK_IDLE) !== IDLE_VEC) begin
            testsFailed++;
            $display("FAIL b2b_idle got_even=%b got_odd=%b exp=%b", obsE(), obsO(), IDLE_VEC);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        din = 8'h3C;
        din_valid = 1'b1;
        errInj = 1'b0;
        for (int ph = 0; ph <= 3; ph++) begin
            @(negedge clk);
            if (ph == 0) din_valid = 1'b0;
            testsRun++;
            if (obsE() !== expVec(ph, 8'h3C, 0, 1'b0)) begin
                testsFailed++;
                $display("FAIL midrst_frame ph=%0d got=%b exp=%b",
                         ph, obsE(), expVec(ph, 8'h3C, 0, 1'b0));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        testsRun++;
        if (obsE() !== IDLE_VEC || obsO() !== IDLE_VEC) begin
            testsFailed++;
            $display("FAIL midrst_abort got_even=%b got_odd=%b exp=%b", obsE(), obsO(), IDLE_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            testsRun++;
            if ((obsE() & MASK_ALL) !== IDLE_VEC) begin
                testsFailed++;
                $display("FAIL midrst_quiet i=%0d got=%b exp=%b", i, obsE(), IDLE_VEC);
            end
        end
    endtask

    task automatic test_ignored_input();
        @(negedge clk);
        din = 8'h0F;
        din_valid = 1'b1;
        errInj = 1'b0;
        for (int ph = 0; ph <= int'(W); ph++) begin
            @(negedge clk);
            if (ph == 0) din_valid = 1'b0;
            if (ph == 2) begin
                din = 8'hFF;
                din_valid = 1'b1;
            end
            if (ph == 4) din_valid = 1'b0;
            testsRun++;
            if (obsE() !== expVec(ph, 8'h0F, 0, 1'b0)) begin
                testsFailed++;
                $display("FAIL ignored_frame ph=%0d got=%b exp=%b",
                         ph, obsE(), expVec(ph, 8'h0F, 0, 1'b0));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            testsRun++;
            if ((obsE() & MASK_IDLE) !== IDLE_VEC) begin
                testsFailed++;
                $display("FAIL ignored_idle i=%0d got=%b exp=%b", i, obsE(), IDLE_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5, 1'b0);
        test_single_frame(8'h07, 1'b0);
        test_single_frame(8'h00, 1'b0);
        test_single_frame(8'hFF, 1'b0);
        test_back_to_back();
        test_reset_mid_frame();
        test_single_frame(8'h80, 1'b0);
        test_ignored_input();
        test_single_frame(8'hA5, 1'b1);
        test_single_frame(8'hA5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            test_single_frame(W'($urandom), 1'($urandom_range(0, 1)));
        end
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
